// File: rtl/flag_unit.sv
// flag_unit
//
// Architectural flag register {V, N, Z} and flag-hazard detector.
//
// Flags are captured from the instruction leaving EX, and what gets written
// depends on the opcode class. The registered flags feed branch resolution
// in ID.
//
// A conditional branch in ID must stall while an older flag-writing
// instruction still sits in EX. This block raises that stall request.
//
// A saturating counter tallies the stall cycles for performance analysis.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   ex_valid     EX holds a valid instruction
//   ex_advance   EX instruction moves to MEM at this edge
//   ex_flush     kill the EX instruction (no flag write)
//   ex_opcode    [3:0] opcode of the EX instruction
//   ex_result    [15:0] ALU result of the EX instruction
//   ex_ovfl      ALU overflow of the EX instruction
//   id_branch    ID holds a B or BR instruction
//   id_cond      [2:0] branch condition, 3'b111 = unconditional
//   stall_clr    synchronous clear of stall_cnt
//   flags        [2:0] registered {V, N, Z}
//   flag_hazard  combinational stall request
//   stall_cnt    [15:0] registered saturating count of hazard cycles
module flag_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_advance,
  input  logic        ex_flush,
  input  logic [3:0]  ex_opcode,
  input  logic [15:0] ex_result,
  input  logic        ex_ovfl,
  input  logic        id_branch,
  input  logic [2:0]  id_cond,
  input  logic        stall_clr,
  output logic [2:0]  flags,
  output logic        flag_hazard,
  output logic [15:0] stall_cnt
);

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpXor = 4'b0010;
  localparam logic [3:0] OpSll = 4'b0100;
  localparam logic [3:0] OpSra = 4'b0101;
  localparam logic [3:0] OpRor = 4'b0110;

  localparam logic [2:0] CondAlways = 3'b111;

  logic [2:0]  flags_q, flags_d;
  logic [15:0] cnt_q, cnt_d;

  logic commitEx;
  logic fullUpdate;
  logic zeroOnly;
  logic writesFlags;
  logic resultZero;
  logic hazard;

  // Decode the EX opcode class.
  // Only a committing instruction may change the flags. A flushed or held
  // instruction leaves them untouched.
  always_comb begin
    commitEx    = ex_valid & ex_advance & ~ex_flush;
    fullUpdate  = (ex_opcode == OpAdd) | (ex_opcode == OpSub);
    zeroOnly    = (ex_opcode == OpXor) | (ex_opcode == OpSll) |
                  (ex_opcode == OpSra) | (ex_opcode == OpRor);
    writesFlags = fullUpdate | zeroOnly;
    resultZero  = (ex_result == 16'h0000);
  end

  // The hazard ignores ex_advance on purpose.
  // The branch cannot resolve in the same cycle the flags are being
  // written, because the new value is visible only from the next cycle.
  // So the stall holds for every cycle the writer is in EX, including the
  // cycle it leaves.
  always_comb begin
    hazard = id_branch & (id_cond != CondAlways) & ex_valid & ~ex_flush &
             writesFlags;
  end

  // Next-state flags.
  // Arithmetic ops rewrite all three flags.
  // Logic and shift ops rewrite only Z, and V and N carry over.
  always_comb begin
    flags_d = flags_q;
    if (commitEx && fullUpdate) begin
      flags_d = {ex_ovfl, ex_result[15], resultZero};
    end else if (commitEx && zeroOnly) begin
      flags_d[0] = resultZero;
    end
  end

  // Next-state stall counter.
  // A clear wins over a simultaneous hazard.
  // The count sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_clr) begin
      cnt_d = 16'h0000;
    end else if (hazard && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'h0001;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 3'b000;
      cnt_q   <= 16'h0000;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  assign flags       = flags_q;
  assign flag_hazard = hazard;
  assign stall_cnt   = cnt_q;

endmodule
